// File: rtl/scfifo_wr_arbiter_if.sv
// Bundle of the producer-lane handshake and the FIFO write-port signals that
// pass through the round-robin write arbiter.
//   master : environment view (producers plus the FIFO read side)
//   slave  : arbiter view
interface scfifo_wr_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 20,
  parameter int LOG_DEPTH = 5
);
  localparam int TAG_W = $clog2(NUM_REQ);

  // Producer lanes
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;

  // FIFO write port and credit return
  logic                     fifo_wrreq;
  logic [WIDTH-1:0]         fifo_data;
  logic [TAG_W-1:0]         fifo_tag;
  logic                     fifo_rdreq;

  // Status
  logic [LOG_DEPTH-1:0]     occupancy;
  logic                     err_underflow;

  modport master (
    output req_valid, req_data, fifo_rdreq,
    input  req_ready, fifo_wrreq, fifo_data, fifo_tag, occupancy, err_underflow
  );

  modport slave (
    input  req_valid, req_data, fifo_rdreq,
    output req_ready, fifo_wrreq, fifo_data, fifo_tag, occupancy, err_underflow
  );
endinterface

// File: rtl/scfifo_wr_arbiter.sv
// Round-robin write arbiter sharing one single-clock FIFO write port between
// NUM_REQ producers. A local credit counter (occupancy) is bumped at grant
// time and returned by the FIFO rdreq copy, so the real FIFO fill level never
// exceeds it and the FIFO can never overflow. The write strobe, data and tag
// toward the FIFO are registered: a grant in cycle N writes in cycle N+1.
module scfifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 20,
  parameter int LOG_DEPTH = 5
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                sclr,
  scfifo_wr_arbiter_if.slave  bus
);

  localparam int TAG_W = $clog2(NUM_REQ);
  // FIFO capacity 2**LOG_DEPTH - 1 is the all-ones value of the counter.
  localparam logic [LOG_DEPTH-1:0] CAP      = {LOG_DEPTH{1'b1}};
  localparam logic [TAG_W-1:0]     LAST_IDX = TAG_W'(NUM_REQ - 1);

  // Candidate index base+off, wrapped into 0..NUM_REQ-1 (off is 1..NUM_REQ).
  function automatic logic [TAG_W-1:0] rr_index(input logic [TAG_W-1:0] base,
                                                input int               off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end else begin
      sum = sum;
    end
    return TAG_W'(sum);
  endfunction

  // State
  logic                 wrreq_q, wrreq_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [LOG_DEPTH-1:0] occ_q, occ_d;
  logic                 err_q, err_d;
  logic [TAG_W-1:0]     last_q, last_d;

  // Combinational
  logic                 can_issue_s;
  logic                 found_s;
  logic [TAG_W-1:0]     grant_idx_s;
  logic [NUM_REQ-1:0]   grant_vec_s;
  logic [WIDTH-1:0]     grant_data_s;
  logic                 underflow_s;

  // A read in the same cycle is deliberately not credited here; waiting one
  // cycle at full keeps the credit path free of the rdreq-to-ready loop.
  assign can_issue_s = resetn & ~sclr & (occ_q < CAP);

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    found_s     = 1'b0;
    grant_idx_s = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (can_issue_s && !found_s && bus.req_valid[rr_index(last_q, k)]) begin
        found_s     = 1'b1;
        grant_idx_s = rr_index(last_q, k);
      end else begin
        found_s     = found_s;
        grant_idx_s = grant_idx_s;
      end
    end
  end

  // One-hot grant vector and the data lane of the granted requester.
  always_comb begin
    grant_vec_s  = '0;
    grant_data_s = bus.req_data[int'(grant_idx_s)*WIDTH +: WIDTH];
    if (found_s) begin
      grant_vec_s[grant_idx_s] = 1'b1;
    end else begin
      grant_vec_s = '0;
    end
  end

  assign bus.req_ready = grant_vec_s;

  // A read with nothing credited and no grant to pay for it is an underflow.
  assign underflow_s = bus.fifo_rdreq & (occ_q == {LOG_DEPTH{1'b0}}) & ~found_s;

  // Credit counter: +1 per grant, -1 per FIFO read, cleared by sclr.
  always_comb begin
    occ_d = occ_q;
    if (sclr) begin
      occ_d = '0;
    end else if (underflow_s) begin
      occ_d = '0;
    end else if (found_s && !bus.fifo_rdreq) begin
      occ_d = occ_q + LOG_DEPTH'(1);
    end else if (!found_s && bus.fifo_rdreq) begin
      occ_d = occ_q - LOG_DEPTH'(1);
    end else begin
      occ_d = occ_q;
    end
  end

  // Write-port and arbitration-pointer next state.
  always_comb begin
    wrreq_d = 1'b0;
    data_d  = data_q;
    tag_d   = tag_q;
    last_d  = last_q;
    err_d   = err_q | underflow_s;
    if (sclr) begin
      // Writes are dropped while the FIFO is being cleared; priority
      // restarts at requester 0.
      wrreq_d = 1'b0;
      last_d  = LAST_IDX;
    end else if (found_s) begin
      wrreq_d = 1'b1;
      data_d  = grant_data_s;
      tag_d   = grant_idx_s;
      last_d  = grant_idx_s;
    end else begin
      // No grant: strobe low, data/tag/pointer hold.
      wrreq_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wrreq_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
      occ_q   <= '0;
      err_q   <= 1'b0;
      last_q  <= LAST_IDX;
    end else begin
      wrreq_q <= wrreq_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      occ_q   <= occ_d;
      err_q   <= err_d;
      last_q  <= last_d;
    end
  end

  assign bus.fifo_wrreq    = wrreq_q;
  assign bus.fifo_data     = data_q;
  assign bus.fifo_tag      = tag_q;
  assign bus.occupancy     = occ_q;
  assign bus.err_underflow = err_q;

endmodule
